// File: rtl/lc3b_dcache_pkg.sv
// Shared types and helpers for the LC-3b MEM-stage data-cache responder.
package lc3b_dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MISS_WAIT,
    FILL,
    WR_WAIT,
    WR_DONE
  } dcache_state_t;

  localparam logic [1:0] WE_READ = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  // Replace only the byte lanes selected by the write enable.
  function automatic logic [15:0] byte_merge(input logic [15:0] old,
                                             input logic [15:0] din,
                                             input logic [1:0]  we);
    logic [15:0] res;
    res = old;
    if (we == WE_LO || we == WE_WORD) res[7:0]  = din[7:0];
    if (we == WE_HI || we == WE_WORD) res[15:8] = din[15:8];
    return res;
  endfunction

endpackage

// File: rtl/lc3b_dcache_tagram.sv
// Direct-mapped line store: valid/tag/data arrays with combinational lookup,
// synchronous write and asynchronous clearing of the valid bits.
module lc3b_dcache_tagram
  import lc3b_dcache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_W      = 15 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  hit,
  output logic [15:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [15:0]           wr_data
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [15:0]      data_q [LINES];

  assign hit     = valid[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/lc3b_dcache_resp.sv
// Write-through, no-write-allocate data cache plus 64 KB backing memory model.
// Define DCACHE_STATS_EN to add saturating hit/miss/write counters.
module lc3b_dcache_resp
  import lc3b_dcache_pkg::*;
#(
  parameter int INDEX_BITS   = 4,
  parameter int MISS_LATENCY = 4,
  parameter int WR_LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dcache_en,
  input  logic [1:0]  dcache_we,
  input  logic [15:0] dcache_addr,
  input  logic [15:0] dcache_din,
  output logic        dcache_r,
  output logic [15:0] dcache_dout
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
  output logic [15:0] stat_writes
`endif
);

  localparam int TAG_W   = 15 - INDEX_BITS;
  localparam int MAX_LAT = (MISS_LATENCY > WR_LATENCY) ? MISS_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  dcache_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [14:0]      req_addr;
  logic [1:0]       req_we;
  logic             accept;
  logic             line_wr;
  logic [15:0]      line_wdata;
  logic             mem_wr;
  logic [14:0]      lk_addr;
  logic             hit;
  logic [15:0]      line_data;
  logic [15:0]      mem_rd;
  logic [15:0]      mem [32768];
  logic             unused_addr_lsb;

  assign unused_addr_lsb = dcache_addr[0];

  // Look up the live address while idle, the captured one while sequencing.
  assign lk_addr = (state == IDLE) ? dcache_addr[15:1] : req_addr;
  assign mem_rd  = mem[req_addr];

  lc3b_dcache_tagram #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TAG_W)
  ) u_tagram (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_idx (lk_addr[INDEX_BITS-1:0]),
    .rd_tag (lk_addr[14:INDEX_BITS]),
    .hit    (hit),
    .rd_data(line_data),
    .wr_en  (line_wr),
    .wr_idx (req_addr[INDEX_BITS-1:0]),
    .wr_tag (req_addr[14:INDEX_BITS]),
    .wr_data(line_wdata)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dcache_r    = 1'b0;
    dcache_dout = 16'h0000;
    accept      = 1'b0;
    line_wr     = 1'b0;
    line_wdata  = mem_rd;
    mem_wr      = 1'b0;
    case (state)
      IDLE: begin
        if (dcache_en) begin
          if (dcache_we == WE_READ) begin
            if (hit) begin
              dcache_r    = 1'b1;
              dcache_dout = line_data;
            end else begin
              accept    = 1'b1;
              cnt_nxt   = CNT_W'(MISS_LATENCY - 1);
              state_nxt = MISS_WAIT;
            end
          end else begin
            accept    = 1'b1;
            cnt_nxt   = CNT_W'(WR_LATENCY - 1);
            state_nxt = WR_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        if (cnt == '0) state_nxt = FILL;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      FILL: begin
        line_wr   = 1'b1;
        state_nxt = IDLE;
      end
      WR_WAIT: begin
        if (!dcache_en)     state_nxt = IDLE;
        else if (cnt == '0) state_nxt = WR_DONE;
        else                cnt_nxt   = cnt - CNT_W'(1);
      end
      WR_DONE: begin
        dcache_r   = 1'b1;
        mem_wr     = 1'b1;
        line_wr    = hit;
        line_wdata = byte_merge(line_data, dcache_din, req_we);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= dcache_addr[15:1];
      req_we   <= dcache_we;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[req_addr] <= byte_merge(mem_rd, dcache_din, req_we);
  end

`ifdef DCACHE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_writes <= '0;
    end else begin
      if (state == IDLE && dcache_r)         stat_hits   <= sat_inc(stat_hits);
      if (state == IDLE && state_nxt == MISS_WAIT) stat_misses <= sat_inc(stat_misses);
      if (state == WR_DONE)                  stat_writes <= sat_inc(stat_writes);
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_dcache_resp.sv
// Directed bench for the LC-3b data-cache responder (default parameters).
module tb_lc3b_dcache_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dcache_en = 1'b0;
  logic [1:0]  dcache_we = 2'b00;
  logic [15:0] dcache_addr = 16'h0000;
  logic [15:0] dcache_din = 16'h0000;
  logic        dcache_r;
  logic [15:0] dcache_dout;
`ifdef DCACHE_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_writes;
`endif

  int errors = 0;
  int checks = 0;

  lc3b_dcache_resp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dcache_en  (dcache_en),
    .dcache_we  (dcache_we),
    .dcache_addr(dcache_addr),
    .dcache_din (dcache_din),
    .dcache_r   (dcache_r),
    .dcache_dout(dcache_dout)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses),
    .stat_writes(stat_writes)
`endif
  );

  always #5 clk = ~clk;

  // Holds a request until dcache_r; cyc = cycle index of dcache_r (40 = timed out).
  task automatic do_req(input logic [1:0] we, input logic [15:0] addr,
                        input logic [15:0] din, input bit keep,
                        output int cyc, output logic [15:0] d);
    bit got;
    got = 1'b0;
    cyc = 0;
    d = 16'hxxxx;
    dcache_en = 1'b1;
    dcache_we = we;
    dcache_addr = addr;
    dcache_din = din;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (dcache_r) begin
        got = 1'b1;
        d = dcache_dout;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (got) begin
      @(posedge clk); #1;
    end
    if (!keep) begin
      dcache_en = 1'b0;
      dcache_we = 2'b00;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dcache_r !== 1'b0) begin errors++; $display("FAIL rst_r: got %b want 0", dcache_r); end
    checks++; if (dcache_dout !== 16'h0000) begin errors++; $display("FAIL rst_dout: got %h want 0000", dcache_dout); end
`ifdef DCACHE_STATS_EN
    checks++; if ({stat_hits, stat_misses, stat_writes} !== 48'h0) begin errors++; $display("FAIL rst_stats: got %h %h %h want 0", stat_hits, stat_misses, stat_writes); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    dcache_addr = 16'h4000;
    @(negedge clk);
    checks++; if (dcache_r !== 1'b0) begin errors++; $display("FAIL idle_noen_r: got %b want 0", dcache_r); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss_hit();
    int c; logic [15:0] d;
    do_req(2'b11, 16'h4000, 16'h80FF, 1'b0, c, d);
    checks++; if (c !== 3) begin errors++; $display("FAIL preload_cyc: got %0d want 3", c); end
    do_req(2'b00, 16'h4000, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 6) begin errors++; $display("FAIL miss_cyc: got %0d want 6", c); end
    checks++; if (d !== 16'h80FF) begin errors++; $display("FAIL miss_dout: got %h want 80ff", d); end
    do_req(2'b00, 16'h4000, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 0) begin errors++; $display("FAIL hit_cyc: got %0d want 0", c); end
    checks++; if (d !== 16'h80FF) begin errors++; $display("FAIL hit_dout: got %h want 80ff", d); end
  endtask

  task automatic test_word_store();
    int c; logic [15:0] d;
    do_req(2'b11, 16'h4000, 16'hA1B2, 1'b0, c, d);
    checks++; if (c !== 3) begin errors++; $display("FAIL st_word_cyc: got %0d want 3", c); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL st_word_dout: got %h want 0000", d); end
    do_req(2'b00, 16'h4000, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 0) begin errors++; $display("FAIL st_word_rd_cyc: got %0d want 0", c); end
    checks++; if (d !== 16'hA1B2) begin errors++; $display("FAIL st_word_rd_dout: got %h want a1b2", d); end
  endtask

  task automatic test_byte_store();
    int c; logic [15:0] d;
    do_req(2'b01, 16'h4000, 16'h005A, 1'b0, c, d);
    checks++; if (c !== 3) begin errors++; $display("FAIL st_lo_cyc: got %0d want 3", c); end
    do_req(2'b10, 16'h4001, 16'h5A00, 1'b0, c, d);
    checks++; if (c !== 3) begin errors++; $display("FAIL st_hi_cyc: got %0d want 3", c); end
    do_req(2'b00, 16'h4000, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 0) begin errors++; $display("FAIL st_byte_rd_cyc: got %0d want 0", c); end
    checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL st_byte_rd_dout: got %h want 5a5a", d); end
  endtask

  task automatic test_conflict();
    int c; logic [15:0] d;
    do_req(2'b11, 16'h4020, 16'h7777, 1'b0, c, d);
    checks++; if (c !== 3) begin errors++; $display("FAIL cf_store_cyc: got %0d want 3", c); end
    do_req(2'b00, 16'h4000, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 0) begin errors++; $display("FAIL cf_noalloc_cyc: got %0d want 0", c); end
    checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL cf_noalloc_dout: got %h want 5a5a", d); end
    do_req(2'b00, 16'h4020, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 6) begin errors++; $display("FAIL cf_evict_cyc: got %0d want 6", c); end
    checks++; if (d !== 16'h7777) begin errors++; $display("FAIL cf_evict_dout: got %h want 7777", d); end
    do_req(2'b00, 16'h4000, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 6) begin errors++; $display("FAIL cf_reread_cyc: got %0d want 6", c); end
    checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL cf_reread_dout: got %h want 5a5a", d); end
  endtask

  task automatic test_abort();
    int c; logic [15:0] d; int seen;
    do_req(2'b11, 16'h4040, 16'h1234, 1'b0, c, d);
    checks++; if (c !== 3) begin errors++; $display("FAIL ab_pre_cyc: got %0d want 3", c); end
    dcache_en = 1'b1; dcache_we = 2'b11; dcache_addr = 16'h4040; dcache_din = 16'hDEAD;
    @(posedge clk); #1;
    dcache_en = 1'b0; dcache_we = 2'b00;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (dcache_r) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL ab_no_r: got %0d r cycles want 0", seen); end
    do_req(2'b00, 16'h4040, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 6) begin errors++; $display("FAIL ab_rd_cyc: got %0d want 6", c); end
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL ab_rd_dout: got %h want 1234", d); end
  endtask

  task automatic test_reset_mid_miss();
    int c; logic [15:0] d;
    dcache_en = 1'b1; dcache_we = 2'b00; dcache_addr = 16'h4000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (dcache_r !== 1'b0) begin errors++; $display("FAIL rmm_r: got %b want 0", dcache_r); end
    checks++; if (dcache_dout !== 16'h0000) begin errors++; $display("FAIL rmm_dout: got %h want 0000", dcache_dout); end
`ifdef DCACHE_STATS_EN
    checks++; if ({stat_hits, stat_misses, stat_writes} !== 48'h0) begin errors++; $display("FAIL rmm_stats: got %h %h %h want 0", stat_hits, stat_misses, stat_writes); end
`endif
    dcache_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(2'b00, 16'h4020, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 6) begin errors++; $display("FAIL rmm_rd_cyc: got %0d want 6", c); end
    checks++; if (d !== 16'h7777) begin errors++; $display("FAIL rmm_rd_dout: got %h want 7777", d); end
  endtask

  task automatic test_back_to_back();
    int c; logic [15:0] d;
    do_req(2'b11, 16'h4020, 16'h1357, 1'b1, c, d);
    checks++; if (c !== 3) begin errors++; $display("FAIL b2b_st_cyc: got %0d want 3", c); end
    do_req(2'b00, 16'h4020, 16'h0000, 1'b0, c, d);
    checks++; if (c !== 0) begin errors++; $display("FAIL b2b_rd_cyc: got %0d want 0", c); end
    checks++; if (d !== 16'h1357) begin errors++; $display("FAIL b2b_rd_dout: got %h want 1357", d); end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_word_store();
    test_byte_store();
    test_conflict();
    test_abort();
    test_reset_mid_miss();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3b_dcache_resp.md
Name: lc3b_dcache_resp

Overview:
- Responder end of the MEM-stage data-cache interface (dcache_en/we/addr/din -> dcache_r/dout).
- Direct-mapped, one-word-per-line, write-through, no-write-allocate cache in front of a 64 KB backing memory model with fixed miss and write latencies.
- A read hit answers combinationally, so the same-cycle stall term mem_stall = mem_v & dcache_en & ~dcache_r stays valid.
- Reads and writes that miss or go to backing memory are sequenced by an FSM.

Parameters:
- INDEX_BITS, 4: number of lines = 2**INDEX_BITS; line index is dcache_addr[INDEX_BITS:1].
- MISS_LATENCY, 4: backing-memory read wait cycles, must be >= 1.
- WR_LATENCY, 2: backing-memory write wait cycles, must be >= 1.

Ports:
- clk input 1: the single clock; all state changes on its rising edge.
- rst_n input 1: asynchronous, active-low reset.
- dcache_en input 1: request valid; held high by MEM until dcache_r.
- dcache_we input 2: byte write enables; 00 = read, 01 = low byte, 10 = high byte, 11 = word.
- dcache_addr input 16: byte address; word select is addr[15:1], addr[0] is ignored here because the requester does lane selection.
- dcache_din input 16: write data, already lane-aligned by the requester.
- dcache_r output 1: request complete this cycle.
- dcache_dout output 16: read data; valid when dcache_r=1 and dcache_we=00, otherwise 16'h0000.

Behaviour:
- Reset:
  - State IDLE, wait counter 0, all line valid bits 0.
  - dcache_r=0, dcache_dout=0.
  - Tags, line data and backing memory are not reset.
  - A reset mid-miss or mid-write aborts the operation with no memory update.
- Addressing: tag = addr[15:INDEX_BITS+1]; hit = valid[idx] & tag[idx] == addr tag.
- FSM states: IDLE, MISS_WAIT, FILL, WR_WAIT, WR_DONE.
- IDLE, read hit: dcache_r=1 and dcache_dout=line data, both combinational, same cycle. State stays IDLE.
- IDLE, read miss: dcache_r=0. Load counter, go to MISS_WAIT.
- MISS_WAIT:
  - Lasts MISS_LATENCY cycles, then goes to FILL.
  - dcache_r=0.
  - Continues to completion even if dcache_en drops.
- FILL:
  - One cycle, dcache_r=0.
  - At its end: line data <= mem[addr[15:1]], tag written, valid set.
  - Next state IDLE, where the still-held request hits.
  - Stall for one read miss = MISS_LATENCY+2 cycles; dcache_r rises in cycle MISS_LATENCY+2 after the first request cycle (cycle 0).
- IDLE, write (we != 00): dcache_r=0. Load counter, go to WR_WAIT.
- WR_WAIT:
  - Lasts WR_LATENCY cycles, then goes to WR_DONE.
  - If dcache_en=0 is sampled in any WR_WAIT cycle: abort to IDLE with no write.
- WR_DONE:
  - dcache_r=1 for exactly one cycle.
  - At its end, backing memory is updated per byte enable.
  - If the line hits, the line data is updated with the same byte merge. A miss does not allocate a line.
  - Next state IDLE.
- The address is captured into a request register on acceptance. Address or din changes after acceptance are ignored, except that WR_DONE merges din sampled in WR_DONE.
- Back-to-back: after WR_DONE or FILL, a request in the next IDLE cycle is evaluated fresh. A store followed by a load to the same word returns the new data.
- dcache_r is never asserted outside IDLE-hit or WR_DONE.
- dcache_en=0 in IDLE: no action, dcache_r=0.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined, adds three output ports:
  - stat_hits (16): increments on each IDLE read-hit cycle with dcache_r=1.
  - stat_misses (16): increments on each IDLE to MISS_WAIT transition.
  - stat_writes (16): increments on each WR_DONE.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package lc3b_dcache_pkg holds:
  - dcache_state_t enum (IDLE, MISS_WAIT, FILL, WR_WAIT, WR_DONE).
  - WE_READ/WE_LO/WE_HI/WE_WORD localparams.
  - Function byte_merge(old, din, we).
- One sub-module, lc3b_dcache_tagram: valid/tag/data arrays, combinational read, synchronous write, asynchronous clear of valid bits.

Test Plan:
- Read miss, then hit: preload mem[0x2000 word] = 16'h80FF, read addr 16'h4000 -> dcache_r=0 for 6 cycles, dcache_r=1 with dout=16'h80FF in cycle 6. Repeat the read -> dcache_r=1 in cycle 0.
- Word store: we=11, addr 16'h4000, din 16'hA1B2 -> dcache_r=1 only in cycle 3. Following read -> hit, dout=16'hA1B2.
- Byte stores: we=01, addr 16'h4000, din 16'h005A, then we=10, addr 16'h4001, din 16'h5A00 -> read returns 16'h5A5A.
- Conflict eviction: read 16'h4000, then 16'h4020 (same idx, INDEX_BITS=4) -> second read misses with 6-cycle stall. Re-read 16'h4000 -> misses again.
- Abort: start a store and drop dcache_en in the first WR_WAIT cycle -> no dcache_r, and memory is unchanged on the next read.
- Reset mid-miss: assert rst_n=0 in MISS_WAIT -> dcache_r=0, and the next read of the same address misses again (valid cleared). With DCACHE_STATS_EN, all counters read 0.
